// File: rtl/apb4_reg_bank_pkg.sv
// Shared definitions for the APB4 register bank: address map constants,
// identification values, FSM state type and the ID lookup helper.
package apb4_reg_bank_pkg;

  localparam logic [11:0] CTRL_OFFSET = 12'hF00;
  localparam logic [11:0] ID_BASE     = 12'hFD0;

  localparam logic [7:0] PID4 = 8'h04;
  localparam logic [7:0] PID5 = 8'h00;
  localparam logic [7:0] PID6 = 8'h00;
  localparam logic [7:0] PID7 = 8'h00;
  localparam logic [7:0] PID0 = 8'h19;
  localparam logic [7:0] PID1 = 8'hB8;
  localparam logic [7:0] PID2 = 8'h1B;
  localparam logic [7:0] CID0 = 8'h0D;
  localparam logic [7:0] CID1 = 8'hF0;
  localparam logic [7:0] CID2 = 8'h05;
  localparam logic [7:0] CID3 = 8'hB1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Word index bits [3:0] within 0xFD0..0xFFC select PID4..7, PID0..3, CID0..3.
  function automatic logic [31:0] id_lookup(input logic [3:0] sel, input logic [3:0] eco);
    logic [31:0] val;
    case (sel)
      4'h4:    val = {24'h000000, PID4};
      4'h5:    val = {24'h000000, PID5};
      4'h6:    val = {24'h000000, PID6};
      4'h7:    val = {24'h000000, PID7};
      4'h8:    val = {24'h000000, PID0};
      4'h9:    val = {24'h000000, PID1};
      4'hA:    val = {24'h000000, PID2};
      4'hB:    val = {24'h000000, eco, 4'h0};
      4'hC:    val = {24'h000000, CID0};
      4'hD:    val = {24'h000000, CID1};
      4'hE:    val = {24'h000000, CID2};
      4'hF:    val = {24'h000000, CID3};
      default: val = 32'h00000000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/apb4_reg_bank_if.sv
// APB4 completer-side bus bundle for the register bank.
interface apb4_reg_bank_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDRWIDTH-1:0] paddr;
  logic [31:0]          pwdata;
  logic [3:0]           pstrb;
  logic [2:0]           pprot;
  logic [31:0]          prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_wait_ctrl.sv
// Transfer sequencer: tracks setup/access phases and inserts WAIT_CYCLES
// wait states before signalling completion.
module apb4_wait_ctrl
  import apb4_reg_bank_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic commit
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;

  // State and wait counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r <= IDLE;
      cnt_r   <= 4'h0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; access phase without prior setup is ignored in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'h0;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'h0;
        end else if (cnt_r != 4'h0) begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = cnt_r - 4'h1;
        end else if (!penable) begin
          state_nxt_s = ACCESS;
          cnt_nxt_s   = WAIT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'h0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'h0;
      end
    endcase
  end

  // Completion: last access cycle with the transfer still selected.
  always_comb begin
    pready = 1'b0;
    commit = 1'b0;
    if ((state_r == ACCESS) && (cnt_r == 4'h0) && psel && penable) begin
      pready = 1'b1;
      commit = 1'b1;
    end else begin
      pready = 1'b0;
      commit = 1'b0;
    end
  end

endmodule

// File: rtl/apb4_reg_bank.sv
// APB4 register bank: NUM_REGS byte-strobed data registers, a lockable
// control register with privilege gating, and the PID/CID block.
module apb4_reg_bank
  import apb4_reg_bank_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  apb4_reg_bank_if.slave          apb,
  input  logic [3:0]              ecorevnum,
  output logic [32*NUM_REGS-1:0]  reg_out,
  output logic [NUM_REGS-1:0]     wr_pulse
);

  logic [ADDRWIDTH-1:0] paddr_s;
  logic [9:0]           word_idx_s;
  logic                 upper_zero_s;
  logic                 data_hit_s;
  logic                 ctrl_hit_s;
  logic                 id_hit_s;
  logic                 err_s;
  logic                 pready_s;
  logic                 commit_s;
  logic                 wr_en_s;
  logic [31:0]          rdata_s;
  logic                 lock_r;
  logic                 priv_r;
  logic                 unused_s;

  assign paddr_s      = apb.paddr;
  assign word_idx_s   = paddr_s[11:2];
  assign upper_zero_s = ((paddr_s >> 12) == {ADDRWIDTH{1'b0}});
  assign data_hit_s   = upper_zero_s && (word_idx_s < 10'(NUM_REGS));
  assign ctrl_hit_s   = upper_zero_s && (word_idx_s == CTRL_OFFSET[11:2]);
  assign id_hit_s     = upper_zero_s && (word_idx_s >= ID_BASE[11:2]);
  assign unused_s     = &{1'b0, paddr_s[1:0], apb.pprot[2:1]};

  apb4_wait_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_ctrl (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (apb.psel),
    .penable (apb.penable),
    .pready  (pready_s),
    .commit  (commit_s)
  );

  // Error classification for the transfer currently on the bus.
  always_comb begin
    err_s = 1'b0;
    if (!(data_hit_s || ctrl_hit_s || id_hit_s)) begin
      err_s = 1'b1;
    end else if (apb.pwrite && id_hit_s) begin
      err_s = 1'b1;
    end else if (apb.pwrite && data_hit_s && lock_r) begin
      err_s = 1'b1;
    end else if (priv_r && !apb.pprot[0]) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  assign wr_en_s = commit_s && apb.pwrite && !err_s;

  // CTRL: LOCK is sticky until reset, PRIV freezes once LOCK is set.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      lock_r <= 1'b0;
      priv_r <= 1'b0;
    end else if (wr_en_s && ctrl_hit_s && apb.pstrb[0]) begin
      lock_r <= lock_r | apb.pwdata[0];
      if (!lock_r) begin
        priv_r <= apb.pwdata[1];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] data_r;
    logic        pulse_r;
    logic        hit_s;

    assign hit_s = wr_en_s && data_hit_s && (word_idx_s == 10'(gi)) && (apb.pstrb != 4'h0);

    // Byte-strobed data register with a one-cycle update strobe.
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        data_r  <= 32'h00000000;
        pulse_r <= 1'b0;
      end else begin
        pulse_r <= hit_s;
        if (hit_s) begin
          for (int b = 0; b < 4; b++) begin
            if (apb.pstrb[b]) begin
              data_r[8*b +: 8] <= apb.pwdata[8*b +: 8];
            end
          end
        end
      end
    end

    assign reg_out[32*gi +: 32] = data_r;
    assign wr_pulse[gi]         = pulse_r;
  end

  // Read mux over data registers, CTRL and the ID block.
  always_comb begin
    rdata_s = 32'h00000000;
    if (data_hit_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rdata_s = rdata_s | ((word_idx_s == 10'(i)) ? reg_out[32*i +: 32] : 32'h00000000);
      end
    end else if (ctrl_hit_s) begin
      rdata_s = {30'h00000000, priv_r, lock_r};
    end else if (id_hit_s) begin
      rdata_s = id_lookup(word_idx_s[3:0], ecorevnum);
    end else begin
      rdata_s = 32'h00000000;
    end
  end

  assign apb.pready  = pready_s;
  assign apb.pslverr = pready_s && err_s;
  assign apb.prdata  = (pready_s && !apb.pwrite && !err_s) ? rdata_s : 32'h00000000;

endmodule

// File: tb/tb_apb4_reg_bank.sv
// Randomised self-checking bench for apb4_reg_bank: a zero-wait and a
// three-wait instance share one APB driver, compared against a register-map model.
module tb_apb4_reg_bank;

  localparam int NR = 8;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h000;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [2:0]  pprot = 3'h0;
  logic [3:0]  ecorevnum = 4'h0;
  int          dsel = 0;

  logic [32*NR-1:0] reg_out0, reg_out3;
  logic [NR-1:0]    pulse0, pulse3;

  apb4_reg_bank_if #(.ADDRWIDTH(12)) bus0 ();
  apb4_reg_bank_if #(.ADDRWIDTH(12)) bus3 ();

  assign bus0.psel = psel && (dsel == 0);
  assign bus3.psel = psel && (dsel == 1);
  assign bus0.penable = penable;  assign bus3.penable = penable;
  assign bus0.pwrite  = pwrite;   assign bus3.pwrite  = pwrite;
  assign bus0.paddr   = paddr;    assign bus3.paddr   = paddr;
  assign bus0.pwdata  = pwdata;   assign bus3.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;    assign bus3.pstrb   = pstrb;
  assign bus0.pprot   = pprot;    assign bus3.pprot   = pprot;

  apb4_reg_bank #(.ADDRWIDTH(12), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .apb(bus0), .ecorevnum(ecorevnum),
    .reg_out(reg_out0), .wr_pulse(pulse0));
  apb4_reg_bank #(.ADDRWIDTH(12), .NUM_REGS(NR), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .apb(bus3), .ecorevnum(ecorevnum),
    .reg_out(reg_out3), .wr_pulse(pulse3));

  logic             obs_pready, obs_pslverr;
  logic [31:0]      obs_prdata;
  logic [32*NR-1:0] obs_regs;
  logic [NR-1:0]    obs_pulse;
  assign obs_pready  = (dsel == 0) ? bus0.pready  : bus3.pready;
  assign obs_pslverr = (dsel == 0) ? bus0.pslverr : bus3.pslverr;
  assign obs_prdata  = (dsel == 0) ? bus0.prdata  : bus3.prdata;
  assign obs_regs    = (dsel == 0) ? reg_out0 : reg_out3;
  assign obs_pulse   = (dsel == 0) ? pulse0 : pulse3;

  // Reference register map, one copy per instance.
  logic [31:0] m_regs [2][NR];
  bit          m_lock [2];
  bit          m_priv [2];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) m_regs[d][i] = 32'h0;
      m_lock[d] = 1'b0;
      m_priv[d] = 1'b0;
    end
  endtask

  function automatic logic [31:0] id_value(input int off);
    logic [7:0] tab [12];
    tab = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h19, 8'hB8, 8'h1B, 8'h00,
            8'h0D, 8'hF0, 8'h05, 8'hB1};
    tab[7] = {ecorevnum, 4'h0};
    return {24'h0, tab[(off - 12'hFD0) / 4]};
  endfunction

  function automatic logic [32*NR-1:0] model_flat(input int d);
    logic [32*NR-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = m_regs[d][i];
    return v;
  endfunction

  task automatic model_xfer(input int d, input bit wr, input logic [11:0] a,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, output bit e,
                            output logic [31:0] rd, output logic [NR-1:0] pulse);
    int  off;
    bit  is_data, is_ctrl, is_id;
    off     = int'(a) & 32'hFFC;
    is_data = off < 4 * NR;
    is_ctrl = off == 32'hF00;
    is_id   = off >= 32'hFD0;
    e = 1'b0; rd = 32'h0; pulse = '0;
    if (!(is_data || is_ctrl || is_id)) e = 1'b1;
    else if (wr && is_id) e = 1'b1;
    else if (wr && is_data && m_lock[d]) e = 1'b1;
    else if (m_priv[d] && !prot[0]) e = 1'b1;
    if (!e && !wr) begin
      if (is_data) rd = m_regs[d][off / 4];
      else if (is_ctrl) rd = {30'h0, m_priv[d], m_lock[d]};
      else rd = id_value(off);
    end else if (!e && wr) begin
      if (is_data) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) m_regs[d][off / 4][8*b +: 8] = data[8*b +: 8];
        if (strb != 4'h0) pulse = NR'(1) << (off / 4);
      end else if (is_ctrl && strb[0]) begin
        if (!m_lock[d]) m_priv[d] = data[1];
        if (data[0]) m_lock[d] = 1'b1;
      end
    end
  endtask

  // Drives one transfer starting at posedge+1; returns at posedge+1 after completion.
  task automatic xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output bit e, output int cyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 2;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (obs_pready) break;
      @(posedge pclk); #1;
      cyc++;
    end
    check("pready_seen", obs_pready, 1'b1);
    rd = obs_prdata;
    e  = obs_pslverr;
    @(posedge pclk); #1;
  endtask

  task automatic run(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [2:0] p,
                     output logic [31:0] rd, output bit e);
    bit me; logic [31:0] mrd; logic [NR-1:0] mp; int cyc;
    model_xfer(dsel, wr, a, d, s, p, me, mrd, mp);
    xfer(wr, a, d, s, p, rd, e, cyc);
    check("pslverr", e, me);
    check("prdata", rd, mrd);
    check("cycles", cyc, (dsel == 0) ? 2 : 5);
    check("wr_pulse", obs_pulse, mp);
    check("reg_out", obs_regs, model_flat(dsel));
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic random_traffic(input int n, input bit priv_prot);
    logic [11:0] a; logic [31:0] rd; bit e, wr; int r;
    for (int t = 0; t < n; t++) begin
      r  = $urandom_range(0, 9);
      wr = $urandom_range(0, 1);
      if (r <= 5)      a = 12'(4 * $urandom_range(0, NR - 1));
      else if (r == 6) a = 12'(32'hFD0 + 4 * $urandom_range(0, 11));
      else if (r == 7) a = 12'(32'h100 + 4 * $urandom_range(0, 32'h37F));
      else if (r == 8) begin a = 12'hF00; wr = 1'b0; end
      else             a = 12'(4 * NR);
      a = a | 12'($urandom_range(0, 3));
      run(wr, a, $urandom, 4'($urandom_range(0, 15)),
          priv_prot ? 3'b001 : 3'($urandom_range(0, 7)), rd, e);
      if ($urandom_range(0, 3) == 0) idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd; bit e; int cyc;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready", {bus0.pready, bus3.pready}, 2'b00);
    check("rst_pslverr", {bus0.pslverr, bus3.pslverr}, 2'b00);
    check("rst_prdata", {bus0.prdata, bus3.prdata}, 64'h0);
    check("rst_regs", {reg_out0, reg_out3}, 512'h0);
    check("rst_pulse", {pulse0, pulse3}, 16'h0);
    @(negedge pclk); presetn = 1'b1;
    @(posedge pclk); #1;

    dsel = 0;
    run(1'b1, 12'h004, 32'hDEADBEEF, 4'b0101, 3'b000, rd, e);
    check("t1_reg1", obs_regs[63:32], 32'h00AD00EF);
    check("t1_pulse", obs_pulse, 8'h02);
    check("t1_err", e, 1'b0);
    idle();
    check("t1_pulse_gone", obs_pulse, 8'h00);
    run(1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, e);
    check("t1_readback", rd, 32'h00AD00EF);
    run(1'b1, 12'h00C, 32'h12345678, 4'h0, 3'b000, rd, e);
    check("strb0_pulse", obs_pulse, 8'h00);
    idle();

    random_traffic(60, 1'b0);
    idle();
    dsel = 1;
    random_traffic(20, 1'b0);
    idle();
    xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'b000, rd, e, cyc);
    check("wait3_cycles", cyc, 5);
    check("wait3_data", rd, m_regs[1][0]);
    idle();

    dsel = 0;
    ecorevnum = 4'hA;
    run(1'b0, 12'hFE0, 32'h0, 4'h0, 3'b000, rd, e);
    check("pid0", rd, 32'h19);
    run(1'b0, 12'hFEC, 32'h0, 4'h0, 3'b000, rd, e);
    check("pid3_eco", rd, 32'hA0);
    run(1'b1, 12'hFE0, 32'h1, 4'hF, 3'b000, rd, e);
    check("id_write_err", e, 1'b1);
    run(1'b0, 12'(4 * NR), 32'h0, 4'h0, 3'b000, rd, e);
    check("past_end_err", e, 1'b1);

    run(1'b1, 12'hF00, 32'h2, 4'h1, 3'b001, rd, e);
    run(1'b0, 12'h000, 32'h0, 4'h0, 3'b000, rd, e);
    check("priv_user_err", e, 1'b1);
    check("priv_user_data", rd, 32'h0);
    run(1'b0, 12'h000, 32'h0, 4'h0, 3'b001, rd, e);
    check("priv_ok", e, 1'b0);

    run(1'b1, 12'hF00, 32'h1, 4'h1, 3'b001, rd, e);
    run(1'b1, 12'h008, 32'hCAFEF00D, 4'hF, 3'b001, rd, e);
    check("lock_err", e, 1'b1);
    run(1'b0, 12'hF00, 32'h0, 4'h0, 3'b001, rd, e);
    check("ctrl_rb", rd, 32'h1);
    run(1'b1, 12'hF00, 32'h0, 4'h1, 3'b001, rd, e);
    run(1'b0, 12'hF00, 32'h0, 4'h0, 3'b001, rd, e);
    check("lock_sticky", rd, 32'h1);
    idle();
    random_traffic(20, 1'b1);
    idle();

    dsel = 1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014;
    pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("mid_rst_pready", bus3.pready, 1'b0);
    check("mid_rst_pslverr", bus3.pslverr, 1'b0);
    check("mid_rst_prdata", bus3.prdata, 32'h0);
    check("mid_rst_regs", {reg_out0, reg_out3}, 512'h0);
    check("mid_rst_pulse", {pulse0, pulse3}, 16'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); presetn = 1'b1;
    model_reset();
    @(posedge pclk); #1;
    run(1'b1, 12'h014, 32'h0BADCAFE, 4'hF, 3'b000, rd, e);
    run(1'b0, 12'h014, 32'h0, 4'h0, 3'b000, rd, e);
    check("post_rst_read", rd, 32'h0BADCAFE);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb4_reg_bank.md
# apb4_reg_bank

Parametrised APB4 completer providing NUM_REGS byte-strobed 32-bit read/write registers, a control register with sticky write lock and privilege gating, programmable wait states, and the standard PID/CID identification block at 0xFD0–0xFFC. It is the next generation of the team's fixed four-register APB4 example slave. It sits on an APB4 peripheral bus segment and exports register contents to local logic.

## Interface
- ADDRWIDTH, 12, APB address width; must be ≥ 12.
- NUM_REGS, 8, number of data registers, 1..64, at offsets 4*i.
- WAIT_CYCLES, 0, wait states inserted per access, 0..15.
- Reset is presetn, asynchronous, active-low; the clock is pclk.
- pclk  in  1  APB clock.
- presetn  in  1  asynchronous active-low reset.
- psel, penable, pwrite  in  1 each  APB4 control.
- paddr  in  ADDRWIDTH  byte address; bits [1:0] ignored.
- pwdata  in  32  write data.
- pstrb  in  4  byte enables.
- pprot  in  3  protection; only bit 0 (privileged) is used.
- ecorevnum  in  4  ECO revision; returned in PID3[7:4].
- prdata  out  32  read data; 0 unless a read completes without error.
- pready  out  1  transfer complete.
- pslverr  out  1  error; valid only while pready=1, otherwise 0.
- reg_out  out  32*NUM_REGS  register i at bits [32i+31:32i].
- wr_pulse  out  NUM_REGS  one-cycle strobe per register update.

## Operation
- Address map:
  - Data registers at 0x000..4*(NUM_REGS-1).
  - CTRL at 0xF00.
  - PID4..7, PID0..3 and CID0..3 at 0xFD0..0xFFC. These return the existing APB4 example constants, except PID3 = {24'h0, ecorevnum, 4'h0}.
  - All other addresses are unmapped.
- CTRL fields:
  - bit0 LOCK: write-1-to-set; cleared only by reset.
  - bit1 PRIV: read/write while LOCK=0; frozen once LOCK=1.
  - bits [31:2] read as 0.
  - CTRL writes honour pstrb[0].
- Error (pslverr=1, no state change, prdata=0) when any of:
  - the address is unmapped;
  - a write targets the ID space;
  - a data-register write occurs while LOCK=1;
  - PRIV=1 and pprot[0]=0, for any access including reads.
- A data write updates only the bytes enabled by pstrb. A write with pstrb=0 still completes OKAY, changes nothing and produces no wr_pulse.
- FSM states: IDLE, ACCESS.
  - IDLE→ACCESS on psel & ~penable (setup phase); the wait counter loads WAIT_CYCLES.
  - In ACCESS, the counter decrements each cycle while it is non-zero.
  - pready = (state==ACCESS) & (cnt==0).
  - ACCESS→IDLE on the cycle with pready=1. If psel & ~penable is also present, back-to-back setup goes to ACCESS with the counter reloaded.
- psel & penable seen in IDLE without a prior setup is a protocol violation: pready stays 0 and nothing is committed until a proper setup occurs.
- psel dropping in ACCESS aborts the transfer: return to IDLE, no commit, pready=0.
- Reset:
  - All data registers, CTRL, counter and wr_pulse go to 0; state goes to IDLE.
  - Outputs pready=0, pslverr=0, prdata=0.
  - Reset mid-transfer discards the write.

## Timing
- Zero-wait (WAIT_CYCLES=0): pready=1 in the first access cycle, giving a 2-cycle transfer.
- Total transfer length is 2+WAIT_CYCLES cycles.
- Writes commit on the pclk edge ending the pready=1 cycle.
- reg_out reflects the new value and wr_pulse[i] is high for the following cycle only.
- prdata and pslverr are combinational from the registered state and paddr, and are qualified by pready.
- A write in transfer N is visible to a read in transfer N+1 with no gap.
- Simultaneous events: a CTRL write setting LOCK blocks data writes starting from the next transfer.

## Structure
- Package apb4_reg_bank_pkg holds:
  - PID/CID localparams;
  - CTRL_OFFSET (0xF00) and the ID base (0xFD0);
  - the state enum {IDLE, ACCESS}.
- Sub-module apb4_wait_ctrl contains the FSM and wait counter. It takes psel, penable and WAIT_CYCLES and produces pready and a commit strobe.
- The top level holds decode, the register array (generate over NUM_REGS), CTRL, error logic and the read mux.

## Test plan
- Write 0xDEADBEEF to reg 1 with pstrb=4'b0101, WAIT_CYCLES=0 → reg 1 = 0x00AD00EF; wr_pulse[1] high one cycle; readback matches; pslverr=0.
- WAIT_CYCLES=3, read of reg 0 → pready low for 3 access cycles, high on the 4th; 5-cycle transfer.
- Write CTRL=0x1, then write reg 2 → pslverr=1, reg 2 unchanged; CTRL readback = 0x1. Writing CTRL=0x0 leaves LOCK=1.
- Write CTRL=0x2, then read reg 0 with pprot=3'b000 → pslverr=1, prdata=0; the same read with pprot=3'b001 → OKAY.
- Read 0xFE0 → 0x19. Read 0xFEC with ecorevnum=4'hA → 0xA0. Write 0xFE0 → pslverr=1. Read 4*NUM_REGS → pslverr=1.
- Assert presetn low during the ACCESS wait phase of a write → no update, all outputs 0; the first transfer after reset completes normally.
